md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the MIPS pipeline. It sits beside the EX-stage ALU and models the latency of `mult`/`multu`/`div`/`divu` with a busy counter. It owns HI/LO and handles `mthi`/`mtlo`. The hazard unit stalls HI/LO-touching instructions in EX while `busy | start` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu` (must be ≥1).
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu` (must be ≥1).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: an MD instruction is in EX this cycle.
- `md_op` in 3: operation code.
  - 0 none, 1 `mult`, 2 `multu`, 3 `div`, 4 `divu`, 5 `mthi`, 6 `mtlo`; codes 7+ are treated as none.
- `a` in 32: rs value / dividend / multiplicand, or the source for `mthi`/`mtlo`.
- `b` in 32: rt value / divisor / multiplier.
- `busy` out 1: an operation is in flight.
- `hi` out 32: HI register, read directly by `mfhi`.
- `lo` out 32: LO register, read directly by `mflo`.

## Operation
- Two states, IDLE and RUN, plus a down-counter `cnt` sized to hold `max(MULT_CYCLES, DIV_CYCLES)`.
- Accept rule: `start` is honoured only in IDLE. In RUN, `start` and `md_op` are ignored entirely: no latch, no HI/LO write, no restart.
- IDLE with `start` and `md_op` 1–4:
  - compute the 64-bit result from `a`/`b` and hold it in internal `res_hi`/`res_lo`;
  - load `cnt` with the op's cycle count;
  - go to RUN.
- RUN behaviour:
  - `cnt` decrements each cycle.
  - On the cycle where `cnt == 1`, the edge writes `res_hi`→`hi` and `res_lo`→`lo` and returns to IDLE.
- IDLE with `start` and `md_op` 5: `hi <= a` at the edge. With `md_op` 6: `lo <= a`. Neither op sets `busy`.
- `busy` is high exactly while in RUN, i.e. `busy = (state == RUN)`.
- Arithmetic:
  - `mult`: `{hi,lo} = $signed(a) * $signed(b)`, full 64-bit product.
  - `multu`: same as `mult`, but unsigned.
  - `div`: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `div` with `0x80000000 / 0xFFFFFFFF`: LO = 0x80000000, HI = 0.
  - `divu`: unsigned quotient and remainder.
  - Divide by zero (`b == 0`, `div` or `divu`): the busy sequence runs normally, but HI and LO keep their pre-operation values at completion.
- Result registers are only loaded on accept, so operand changes during RUN have no effect.

## Timing
- Reset values: `busy = 0`, `hi = 0`, `lo = 0`, state IDLE, `cnt = 0`, pending result discarded.
- Accept at edge t (start sampled high in IDLE):
  - `busy` is high for cycles t+1 … t+N, where N is the op's cycle count;
  - new `hi`/`lo` are visible from cycle t+N+1, in the same cycle `busy` falls;
  - until then `hi`/`lo` hold their old values.
- Back-to-back: a `start` sampled in the cycle `busy` has just fallen is accepted. The minimum spacing between two MD ops is therefore N+1 edges.
- `mthi`/`mtlo` have 1-cycle latency: the value is visible the cycle after the accepting edge.
- Reset asserted mid-RUN: at the next edge all state returns to reset values and the in-flight result is lost. Reset has priority over `start` in the same cycle.
- `hi`/`lo` outputs are registered only; there is no combinational path from `a`/`b` to outputs.

## Test plan
- Reset, then `mult` with a = 0xFFFFFFFD (−3), b = 5 → `busy` high exactly 5 cycles; then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- `multu` with a = 0xFFFFFFFF, b = 2 → `hi` = 0x00000001, `lo` = 0xFFFFFFFE after 5 busy cycles.
- `div` with a = 0xFFFFFFF9 (−7), b = 2 → `busy` for 10 cycles; then `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - Immediately after, `divu` with a = 7, b = 2 → `lo` = 3, `hi` = 1.
- `mthi` a = 0x12345678 then `mtlo` a = 0x9ABCDEF0 in IDLE → values visible next cycle and `busy` stays 0.
  - Then `divu` with b = 0 → 10 busy cycles, `hi`/`lo` still 0x12345678 / 0x9ABCDEF0.
- Start `div`, assert `start` with `mtlo` a = 0xDEADBEEF in busy cycle 3 → `mtlo` is ignored and the div result lands on time.
  - Start another `mult` and assert `reset` in busy cycle 2 → next cycle `busy` = 0, `hi` = `lo` = 0, and no later write occurs.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, ncnt;
  logic [31:0] res_hi, res_lo, dv, uq, ur;
  logic signed [31:0] sq, sr;
  logic signed [63:0] sx, sy, sp;
  logic [63:0] up, nres;
  logic res_wr, accept, is_md, done, ovf;
  // Operand datapath; the divisor is forced to 1 for divide-by-zero and INT_MIN/-1 so neither traps
  always_comb begin
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    dv = (b == 32'd0 || ovf) ? 32'd1 : b;
    sx = $signed(a);
    sy = $signed(b);
    sp = sx * sy;
    up = {32'd0, a} * {32'd0, b};
    sq = $signed(a) / $signed(dv);
    sr = $signed(a) % $signed(dv);
    uq = a / dv;
    ur = a % dv;
    nres = md_op == 3'd1 ? sp : md_op == 3'd2 ? up : md_op == 3'd3 ? {sr, sq} : {ur, uq};
    ncnt = md_op < 3'd3 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
  end
  // Next-state logic: accept only in IDLE, leave RUN on the last counted cycle
  always_comb begin
    accept = state == IDLE && start;
    is_md = md_op != 3'd0 && md_op < 3'd5;
    done = state == RUN && cnt == CW'(1);
    nxt = state == IDLE ? (accept && is_md ? RUN : IDLE) : (done ? IDLE : RUN);
  end
  assign busy = state == RUN;
  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= nxt;
      if (accept && is_md) begin
        res_hi <= nres[63:32];
        res_lo <= nres[31:0];
        res_wr <= !(md_op > 3'd2 && b == 32'd0);
        cnt <= ncnt;
      end else if (state == RUN) cnt <= cnt - CW'(1);
      if (done && res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (accept && md_op == 3'd5) hi <= a;
      if (accept && md_op == 3'd6) lo <= a;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit
module tb_md_unit;
  logic clk = 0, reset = 1, start = 0, busy;
  logic [2:0] md_op = 0;
  logic [31:0] a = 0, b = 0, hi, lo, m_hi = 0, m_lo = 0;
  logic [63:0] sb[$];
  int total = 0, bad = 0;

  md_unit dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
               .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int n, input int inj);
    logic [63:0] e;
    int c;
    sb.push_back({eh, el});
    md_op = op; a = x; b = y; start = 1;
    tick();
    start = 0; md_op = 0; a = $urandom; b = $urandom;
    chk("hold_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("hold_lo", {32'd0, lo}, {32'd0, m_lo});
    c = 0;
    while (busy && c < 40) begin
      c++;
      if (c == inj) begin start = 1; md_op = 6; a = 32'hDEADBEEF; end
      tick();
      start = 0; md_op = 0;
    end
    chk("busy_len", 64'(c), 64'(n));
    e = sb.pop_front();
    chk("res_hi", {32'd0, hi}, {32'd0, e[63:32]});
    chk("res_lo", {32'd0, lo}, {32'd0, e[31:0]});
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 0;
    tick();
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0);
    run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0);
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 5, 0);
    md_op = 5; a = 32'h12345678; start = 1;
    tick();
    chk("mthi_hi", {32'd0, hi}, 64'h12345678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    md_op = 6; a = 32'h9ABCDEF0;
    tick();
    start = 0; md_op = 0;
    chk("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
    chk("mtlo_hi", {32'd0, hi}, 64'h12345678);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    run_op(3'd4, 32'd99, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10, 0);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3);
    md_op = 1; a = 32'd3; b = 32'd3; start = 1;
    tick();
    start = 0; md_op = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    repeat (8) tick();
    chk("post_rst_hi", {32'd0, hi}, 64'd0);
    chk("post_rst_lo", {32'd0, lo}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    reset = 1; start = 1; md_op = 5; a = 32'h55;
    tick();
    reset = 0; start = 0; md_op = 0;
    chk("rst_prio_hi", {32'd0, hi}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
